// File: rtl/dsp_seq_pkg.sv
// Shared field layout and state encoding for the DSP slice test sequencer.
// Command and result bit positions match the control block's dout/din words.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_DRIVE,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_e;

  localparam int A_LSB       = 0;
  localparam int B_LSB       = 18;
  localparam int LAT_LSB     = 36;
  localparam int LAT_W       = 4;
  localparam int ITER_LSB    = 40;
  localparam int ITER_W      = 8;
  localparam int ACC_CLR_BIT = 48;
  localparam int DUT_RST_BIT = 49;

  localparam int RES_P_LSB   = 0;
  localparam int RES_CNT_LSB = 48;
  localparam int RES_CNT_W   = 8;
  localparam int RES_OVR_BIT = 63;

  localparam int DUT_RST_CYCLES = 2;

endpackage

// File: rtl/dsp_seq.sv
// Latches a command, drives the DSP for ITER+1 iterations of LAT-cycle latency, returns P + status.
// Latency: first dut_ce 1 cycle after strobe (3 with DUT_RST); no backpressure, strobes while busy are dropped and flagged.
module dsp_seq
  import dsp_seq_pkg::*;
#(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 48,
  parameter int CMD_WIDTH = 64,
  parameter int RES_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 strobe,
  input  logic [CMD_WIDTH-1:0] cmd,
  output logic [RES_WIDTH-1:0] result,
  output logic                 busy,
  output logic                 done,
  output logic [A_WIDTH-1:0]   dut_a,
  output logic [B_WIDTH-1:0]   dut_b,
  output logic                 dut_ce,
  output logic                 dut_rst,
  output logic                 dut_load,
  input  logic [P_WIDTH-1:0]   dut_p
);

  localparam logic [1:0] RST_LAST = 2'(DUT_RST_CYCLES - 1);

  state_e                 state_q;
  logic [A_WIDTH-1:0]     a_q;
  logic [B_WIDTH-1:0]     b_q;
  logic [LAT_W-1:0]       lat_q;
  logic [LAT_W-1:0]       lat_cnt_q;
  logic [ITER_W-1:0]      iter_q;
  logic                   clr_q;
  logic                   first_q;
  logic [1:0]             rst_cnt_q;
  logic [P_WIDTH-1:0]     p_q;
  logic [RES_CNT_W-1:0]   res_cnt_q;
  logic                   ovr_q;
  logic [A_WIDTH-1:0]     dut_a_q;
  logic [B_WIDTH-1:0]     dut_b_q;
  logic                   dut_ce_q;
  logic                   dut_rst_q;
  logic                   dut_load_q;
  logic                   done_q;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd[CMD_WIDTH-1:DUT_RST_BIT+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      lat_q      <= '0;
      lat_cnt_q  <= '0;
      iter_q     <= '0;
      clr_q      <= 1'b0;
      first_q    <= 1'b0;
      rst_cnt_q  <= '0;
      p_q        <= '0;
      res_cnt_q  <= '0;
      ovr_q      <= 1'b0;
      dut_a_q    <= '0;
      dut_b_q    <= '0;
      dut_ce_q   <= 1'b0;
      dut_rst_q  <= 1'b0;
      dut_load_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (strobe) begin
            a_q     <= cmd[A_LSB +: A_WIDTH];
            b_q     <= cmd[B_LSB +: B_WIDTH];
            lat_q   <= cmd[LAT_LSB +: LAT_W];
            iter_q  <= cmd[ITER_LSB +: ITER_W];
            clr_q   <= cmd[ACC_CLR_BIT];
            first_q <= 1'b1;
            ovr_q   <= 1'b0;
            if (cmd[DUT_RST_BIT]) begin
              state_q   <= S_RST;
              dut_rst_q <= 1'b1;
              rst_cnt_q <= '0;
            end else begin
              state_q    <= S_DRIVE;
              dut_a_q    <= cmd[A_LSB +: A_WIDTH];
              dut_b_q    <= cmd[B_LSB +: B_WIDTH];
              dut_ce_q   <= 1'b1;
              dut_load_q <= cmd[ACC_CLR_BIT];
            end
          end
        end
        S_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q    <= S_DRIVE;
            dut_rst_q  <= 1'b0;
            dut_a_q    <= a_q;
            dut_b_q    <= b_q;
            dut_ce_q   <= 1'b1;
            dut_load_q <= clr_q;
          end else begin
            rst_cnt_q <= rst_cnt_q + 2'd1;
          end
        end
        S_DRIVE: begin
          dut_load_q <= 1'b0;
          if (lat_q != '0) begin
            state_q   <= S_WAIT;
            lat_cnt_q <= lat_q;
          end else begin
            state_q  <= S_CAPT;
            dut_ce_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (lat_cnt_q == LAT_W'(1)) begin
            state_q  <= S_CAPT;
            dut_ce_q <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        S_CAPT: begin
          p_q       <= dut_p;
          // First capture restarts the count; 256 iterations wrap it back to 0.
          res_cnt_q <= first_q ? RES_CNT_W'(1) : res_cnt_q + RES_CNT_W'(1);
          first_q   <= 1'b0;
          if (iter_q != '0) begin
            iter_q     <= iter_q - ITER_W'(1);
            state_q    <= S_DRIVE;
            dut_a_q    <= a_q;
            dut_b_q    <= b_q;
            dut_ce_q   <= 1'b1;
            dut_load_q <= 1'b0;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      if (strobe && (state_q != S_IDLE)) begin
        ovr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    result = '0;
    result[RES_P_LSB +: P_WIDTH]     = p_q;
    result[RES_CNT_LSB +: RES_CNT_W] = res_cnt_q;
    result[RES_OVR_BIT]              = ovr_q;
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign dut_a    = dut_a_q;
  assign dut_b    = dut_b_q;
  assign dut_ce   = dut_ce_q;
  assign dut_rst  = dut_rst_q;
  assign dut_load = dut_load_q;

endmodule

// File: tb/tb_dsp_seq.sv
// Directed and randomized bench for dsp_seq with a behavioural DSP slice and result reference model.
module tb_dsp_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe;
  logic [63:0] cmd;
  logic [63:0] result;
  logic        busy, done;
  logic [17:0] dut_a, dut_b;
  logic        dut_ce, dut_rst, dut_load;
  logic [47:0] dut_p;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  `define CHK(tag, obs, exp) \
    begin \
      n_chk++; \
      assert ((obs) === (exp)) n_pass++; \
      else begin \
        n_fail++; \
        $error("FAIL %s: observed %0h, expected %0h", tag, (obs), (exp)); \
      end \
    end

  always #5 clk = ~clk;

  dsp_seq dut (
    .clk     (clk),
    .reset   (reset),
    .strobe  (strobe),
    .cmd     (cmd),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .dut_a   (dut_a),
    .dut_b   (dut_b),
    .dut_ce  (dut_ce),
    .dut_rst (dut_rst),
    .dut_load(dut_load),
    .dut_p   (dut_p)
  );

  // DSP slice: an operation issues on the first ce cycle, P appears after cur_lat further ce cycles.
  int                 cur_lat = 0;
  logic [47:0]        m_acc = '0, m_pend = '0, m_p = '0;
  int                 m_k = 0;
  logic               m_prev_ce = 1'b0;
  logic signed [47:0] m_sa, m_sb;
  logic [47:0]        m_nv;

  assign m_sa  = {{30{dut_a[17]}}, dut_a};
  assign m_sb  = {{30{dut_b[17]}}, dut_b};
  assign m_nv  = (dut_load ? 48'd0 : m_acc) + 48'(m_sa * m_sb);
  assign dut_p = m_p;

  always @(posedge clk) begin
    if (dut_rst) begin
      m_acc     <= '0;
      m_p       <= '0;
      m_k       <= 0;
      m_prev_ce <= 1'b0;
    end else begin
      m_prev_ce <= dut_ce;
      if (dut_ce && !m_prev_ce) begin
        m_acc  <= m_nv;
        m_pend <= m_nv;
        m_k    <= 1;
        if (cur_lat == 0) m_p <= m_nv;
      end else if (dut_ce) begin
        m_k <= m_k + 1;
        if (m_k == cur_lat) m_p <= m_pend;
      end
    end
  end

  logic [47:0] ref_acc = '0;

  function automatic logic [63:0] mk_cmd(input logic [17:0] a, input logic [17:0] b,
                                         input int lat, input int iter, input bit clr, input bit dr);
    return {14'($urandom), dr, clr, 8'(iter), 4'(lat), b, a};
  endfunction

  task automatic run_cmd(input logic [17:0] a, input logic [17:0] b, input int lat, input int iter,
                         input bit clr, input bit dr, input int inj_off, input logic [17:0] inj_a);
    int          exp_busy = 2 * int'(dr) + (iter + 1) * (lat + 2) + 1;
    int          busy_n = 0, first_ce = 0, ce_n = 0, load_n = 0, load_k = 0;
    int          rst_n = 0, rst_ce = 0, done_n = 0, done_k = 0, opnd_bad = 0;
    bit          fin = 1'b0;
    logic [47:0] start, exp_p;
    longint      sa, sb;
    cmd     = mk_cmd(a, b, lat, iter, clr, dr);
    strobe  = 1'b1;
    cur_lat = lat;
    for (int k = 1; k <= exp_busy + 50 && !fin; k++) begin
      @(posedge clk); #1;
      if (k == inj_off) begin
        strobe = 1'b1;
        cmd    = mk_cmd(inj_a, b, lat, iter, clr, dr);
      end else begin
        strobe = 1'b0;
      end
      if (dut_ce) begin
        ce_n++;
        if (first_ce == 0) first_ce = k;
        if (dut_a !== a || dut_b !== b) opnd_bad++;
      end
      if (dut_load) begin load_n++; load_k = k; end
      if (dut_rst) begin rst_n++; if (dut_ce) rst_ce++; end
      if (done) begin done_n++; done_k = k; end
      if (busy) busy_n++;
      else fin = 1'b1;
    end
    strobe = 1'b0;

    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    start = (clr || dr) ? 48'd0 : ref_acc;
    exp_p = start + 48'(longint'(iter + 1) * sa * sb);

    `CHK("run_ends", fin, 1'b1)
    `CHK("busy_cycles", busy_n, exp_busy)
    `CHK("first_ce", first_ce, dr ? 3 : 1)
    `CHK("ce_cycles", ce_n, (iter + 1) * (lat + 1))
    `CHK("operands", opnd_bad, 0)
    `CHK("load_cycles", load_n, int'(clr))
    if (clr) `CHK("load_pos", load_k, first_ce)
    `CHK("dut_rst_cycles", rst_n, 2 * int'(dr))
    `CHK("ce_in_rst", rst_ce, 0)
    `CHK("done_pulses", done_n, 1)
    `CHK("done_pos", done_k, exp_busy)
    `CHK("res_p", result[47:0], exp_p)
    `CHK("res_cnt", result[55:48], 8'(iter + 1))
    `CHK("res_zero", result[62:56], 7'd0)
    `CHK("res_ovr", result[63], inj_off > 0)
    ref_acc = exp_p;
  endtask

  initial begin
    reset  = 1'b1;
    strobe = 1'b0;
    cmd    = '0;
    #2 reset = 1'b0;
    #1;
    `CHK("rst_result", result, 64'd0)
    `CHK("rst_outs", {busy, done, dut_ce, dut_rst, dut_load, dut_a, dut_b}, 41'd0)
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    run_cmd(18'd3, 18'd5, 2, 0, 1'b1, 1'b0, 0, 18'd0);
    run_cmd(18'd7, 18'h3FFFE, 3, 3, 1'b1, 1'b0, 0, 18'd0);
    `CHK("neg_p_value", result[47:0], 48'hFFFF_FFFF_FFC8)
    run_cmd(18'd1, 18'd1, 0, 1, 1'b0, 1'b0, 0, 18'd0);
    run_cmd(18'd6, 18'd9, 1, 0, 1'b0, 1'b1, 0, 18'd0);
    // Overrun during WAIT, then in the DONE cycle; each following run starts in the first IDLE cycle.
    run_cmd(18'd9, 18'd4, 3, 0, 1'b1, 1'b0, 2, 18'd100);
    run_cmd(18'd2, 18'd8, 2, 1, 1'b1, 1'b0, 0, 18'd0);
    run_cmd(18'd5, 18'd5, 2, 0, 1'b1, 1'b0, 5, 18'd77);
    run_cmd(18'd4, 18'd3, 1, 2, 1'b0, 1'b0, 0, 18'd0);
    run_cmd(18'h2_0000, 18'h1_FFFF, 15, 0, 1'b1, 1'b0, 0, 18'd0);
    run_cmd(18'd3, 18'd7, 0, 255, 1'b1, 1'b0, 0, 18'd0);

    for (int i = 0; i < 6; i++) begin
      run_cmd(18'($urandom), 18'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 18'd0);
    end

    cmd     = mk_cmd(18'd11, 18'd13, 4, 3, 1'b1, 1'b0);
    strobe  = 1'b1;
    cur_lat = 4;
    @(posedge clk); #1 strobe = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    `CHK("mid_busy", busy, 1'b1)
    `CHK("mid_ce", dut_ce, 1'b1)
    #2 reset = 1'b0;
    #1;
    `CHK("mid_rst_result", result, 64'd0)
    `CHK("mid_rst_outs", {busy, done, dut_ce, dut_rst, dut_load, dut_a, dut_b}, 41'd0)
    #2 reset = 1'b1;
    @(posedge clk); #1;
    `CHK("post_rst_idle", busy, 1'b0)
    run_cmd(18'd12, 18'h3FFFD, 2, 2, 1'b1, 1'b0, 0, 18'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
